// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshakes.
// Stage 1 resolves the lower half; stage 2 selects the upper blocks and forms flags.
module csa_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NB   = WIDTH / BLOCK;
  localparam int HB   = NB / 2;
  localparam int HALF = HB * BLOCK;

  genvar gi;

  logic             s1_valid_reg;
  logic             s2_valid_reg;
  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [BLOCK:0]   blk0;
  logic [NB-1:1][BLOCK:0] cand0;
  logic [NB-1:1][BLOCK:0] cand1;

  logic [HALF-1:0]  lo_sum_next;
  logic             lo_carry_next;

  logic [HALF-1:0]        s1_lo_sum_reg;
  logic                   s1_carry_reg;
  logic [NB-1:HB][BLOCK:0] s1_hi0_reg;
  logic [NB-1:HB][BLOCK:0] s1_hi1_reg;
  logic                   s1_a_msb_reg;
  logic                   s1_b_msb_reg;

  logic [WIDTH-HALF-1:0] hi_sum_next;
  logic                  hi_carry_next;
  logic [WIDTH-1:0]      sum_next;
  logic                  ovf_next;
  logic                  zero_next;

  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             zero_reg;

  // Backpressure ripples from the output toward the input within one cycle.
  assign s2_adv   = ~s2_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_ready = s1_adv;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;

  assign blk0 = {1'b0, a[BLOCK-1:0]} + {1'b0, b_eff[BLOCK-1:0]} + {{BLOCK{1'b0}}, cin_eff};

  generate
    for (gi = 1; gi < NB; gi++) begin : g_blk
      assign cand0[gi] = {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, b_eff[gi*BLOCK +: BLOCK]};
      assign cand1[gi] = {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, b_eff[gi*BLOCK +: BLOCK]}
                       + {{BLOCK{1'b0}}, 1'b1};
    end
  endgenerate

  always_comb begin
    lo_sum_next              = '0;
    lo_sum_next[BLOCK-1:0]   = blk0[BLOCK-1:0];
    lo_carry_next            = blk0[BLOCK];
    for (int k = 1; k < HB; k++) begin
      lo_sum_next[k*BLOCK +: BLOCK] = lo_carry_next ? cand1[k][BLOCK-1:0] : cand0[k][BLOCK-1:0];
      lo_carry_next                 = lo_carry_next ? cand1[k][BLOCK]     : cand0[k][BLOCK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_lo_sum_reg <= '0;
      s1_carry_reg  <= 1'b0;
      s1_hi0_reg    <= '0;
      s1_hi1_reg    <= '0;
      s1_a_msb_reg  <= 1'b0;
      s1_b_msb_reg  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_lo_sum_reg <= lo_sum_next;
        s1_carry_reg  <= lo_carry_next;
        s1_hi0_reg    <= cand0[NB-1:HB];
        s1_hi1_reg    <= cand1[NB-1:HB];
        s1_a_msb_reg  <= a[WIDTH-1];
        s1_b_msb_reg  <= b_eff[WIDTH-1];
      end
    end
  end

  // Upper blocks select in order, each using the carry chosen by the one below.
  always_comb begin
    hi_sum_next   = '0;
    hi_carry_next = s1_carry_reg;
    for (int k = HB; k < NB; k++) begin
      hi_sum_next[(k-HB)*BLOCK +: BLOCK] = hi_carry_next ? s1_hi1_reg[k][BLOCK-1:0]
                                                         : s1_hi0_reg[k][BLOCK-1:0];
      hi_carry_next = hi_carry_next ? s1_hi1_reg[k][BLOCK] : s1_hi0_reg[k][BLOCK];
    end
    sum_next  = {hi_sum_next, s1_lo_sum_reg};
    ovf_next  = (s1_a_msb_reg == s1_b_msb_reg) && (sum_next[WIDTH-1] != s1_a_msb_reg);
    zero_next = ~|sum_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      sum_reg      <= '0;
      c_out_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg   <= sum_next;
        c_out_reg <= hi_carry_next;
        ovf_reg   <= ovf_next;
        zero_reg  <= zero_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

endmodule
